// File: rtl/hex_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_pkg
// Description : Shared types and constants for the hex scan display driver:
//               scan FSM state encoding, the blank pattern and the active-low
//               seven-segment table (bit 6 = g ... bit 0 = a).
// Revision    : 1.0 - initial release
// ============================================================================
package hex_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_decode
// Description : Combinational hex nibble to active-low seven-segment pattern.
//               One instance is shared by all digits of the scan driver.
// Ports       : i_nib  - hex digit value 0..F
//               o_seg  - active-low segments, bit 6 = g ... bit 0 = a
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_decode
    import hex_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_driver
// Description : Scans a packed hex value one digit per clock through a shared
//               decoder, applies optional leading-zero blanking, and commits
//               all digits to the display outputs in a single cycle.
// Ports       : clk            - system clock
//               reset          - asynchronous active-high reset
//               i_value_in     - packed hex value, nibble i -> digit i
//               i_blank_lz     - 1 = blank leading zero digits (never digit 0)
//               i_blink_mask   - per-digit blink enable (HEX_SCAN_BLINK_EN only)
//               o_seg_out      - active-low segments, digit i at [7i+6:7i]
//               o_busy         - high from LOAD through COMMIT
//               o_update_done  - one-cycle pulse when o_seg_out updates
// Config      : define HEX_SCAN_BLINK_EN to add the blink prescaler and an
//               extra output register stage (one more cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] i_value_in,
    input  logic                    i_blank_lz,
`ifdef HEX_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
`endif
    output logic [7*NUM_DIGITS-1:0] o_seg_out,
    output logic                    o_busy,
    output logic                    o_update_done
);

    localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (BLINK_DIV < 2) begin : g_blink_div_chk
            $error("BLINK_DIV must be at least 2");
        end
    endgenerate

    scan_state_t               r_state;
    scan_state_t               w_next_state;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic                      r_shadow_lz;
    logic                      r_pending;
    logic [C_IDX_W-1:0]        r_idx;
    logic                      r_lz_run;
    logic [6:0]                r_stage [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0]   r_seg_commit;
    logic                      r_update_commit;
    logic [3:0]                w_nib;
    logic [6:0]                w_dec;
    logic                      w_commit;

    assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

    hex_seg_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the input compare only matters in IDLE, so changes
    // during a scan are picked up after COMMIT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_pending || (i_value_in != r_shadow) || (i_blank_lz != r_shadow_lz)) begin
                    w_next_state = LOAD;
                end
            end
            LOAD:    w_next_state = SCAN;
            SCAN: begin
                if (r_idx == '0) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy   = (r_state != IDLE);
        w_commit = (r_state == COMMIT);
    end

    // Scan datapath: digits are walked from most to least significant so the
    // leading-zero run can be tracked with a single flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow        <= '0;
            r_shadow_lz     <= 1'b0;
            r_pending       <= 1'b1;
            r_idx           <= '0;
            r_lz_run        <= 1'b0;
            r_seg_commit    <= '1;
            r_update_commit <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_stage[i] <= SEG_BLANK;
            end
        end else begin
            r_update_commit <= w_commit;
            case (r_state)
                LOAD: begin
                    r_shadow    <= i_value_in;
                    r_shadow_lz <= i_blank_lz;
                    r_idx       <= C_IDX_W'(NUM_DIGITS - 1);
                    r_lz_run    <= i_blank_lz;
                    r_pending   <= 1'b0;
                end
                SCAN: begin
                    if (r_lz_run && (w_nib == 4'h0) && (r_idx != '0)) begin
                        r_stage[r_idx] <= SEG_BLANK;
                    end else begin
                        r_stage[r_idx] <= w_dec;
                        r_lz_run       <= 1'b0;
                    end
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_seg_commit[7*i +: 7] <= r_stage[i];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HEX_SCAN_BLINK_EN
    logic [BLINK_DIV-1:0]    r_blink_cnt;
    logic [7*NUM_DIGITS-1:0] w_seg_gated;
    logic [7*NUM_DIGITS-1:0] r_seg_out;
    logic                    r_update_done;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blink
            assign w_seg_gated[7*g +: 7] = (i_blink_mask[g] && r_blink_cnt[BLINK_DIV-1])
                                         ? SEG_BLANK : r_seg_commit[7*g +: 7];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_seg_out     <= '1;
            r_update_done <= 1'b0;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
            r_seg_out     <= w_seg_gated;
            r_update_done <= r_update_commit;
        end
    end

    assign o_seg_out     = r_seg_out;
    assign o_update_done = r_update_done;
`else
    assign o_seg_out     = r_seg_commit;
    assign o_update_done = r_update_commit;
`endif

endmodule
`default_nettype wire
